rr_output_arbiter: RTL and testbench
====================================

Name: rr_output_arbiter

Overview:
Parametrised round-robin arbiter for one router output port. It is the successor to the fixed 4-input, single-direction round-robin processor. Each input presents its next-hop address, and the block filters the requests that target its own port (PORT_ID). It grants exactly one input and holds that grant for a whole packet (head to tail flit). The round-robin pointer advances only when a packet completes. One instance sits per output port, ahead of the crossbar select.

Parameters:
NUM_IN, 4, number of requesting inputs (2..8).
ADDR_W, 3, width of each next-hop address field.
PORT_ID, 3'd0, next-hop code this output port serves.
LOCK_EN, 1, 1 = hold grant until tail flit; 0 = every transfer releases (single-flit mode).
IDX_W, $clog2(NUM_IN), width of the grant index.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
nexthop_addr_i  input  NUM_IN*ADDR_W  packed next-hop addresses; input i occupies bits [i*ADDR_W +: ADDR_W]
valid_i  input  NUM_IN  flit valid per input
tail_i  input  NUM_IN  flit at input i is a tail flit
out_ready_i  input  1  downstream can accept a flit this cycle
grant_o  output  NUM_IN  one-hot registered grant
grant_idx_o  output  IDX_W  binary index of the granted input
grant_valid_o  output  1  a grant is active
transfer_o  output  1  combinational: grant_valid_o & valid_i[grant_idx_o] & out_ready_i
rr_ptr_o  output  IDX_W  current round-robin pointer, for debug and coverage

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- On reset, at the clock edge: state=IDLE, rr_ptr=0, grant_o=0, grant_idx_o=0, grant_valid_o=0. transfer_o is therefore 0.
- Request qualification: req[i] = valid_i[i] & (nexthop_addr_i[i] == PORT_ID). This is evaluated only in IDLE.
- FSM states: IDLE, LOCKED.
- IDLE with req==0: stay in IDLE, outputs hold at 0.
- IDLE with req!=0: select the first i with req[i]=1, scanning cyclically rr_ptr, rr_ptr+1, ..., wrapping NUM_IN-1 to 0.
  - Next edge: grant_o=onehot(i), grant_idx_o=i, grant_valid_o=1, state=LOCKED.
  - Latency from request to grant is 1 cycle.
- LOCKED:
  - Requests from other inputs are ignored.
  - The owner's next-hop address is not re-checked, since body flits carry no address.
  - If the owner drops valid_i, the grant is held.
- Release: occurs on a transfer cycle (transfer_o=1) where tail_i[owner]=1, or on any transfer when LOCK_EN=0. At the next edge:
  - grant_o=0, grant_valid_o=0, state=IDLE.
  - rr_ptr = owner+1, wrapping to 0 when owner=NUM_IN-1 (also for non-power-of-two NUM_IN).
  - grant_idx_o holds its last value.
- There is exactly one idle bubble cycle between release and the next grant. Requests present in the release cycle are arbitrated in the following IDLE cycle.
- rr_ptr changes only on release, never on grant.
- Reset asserted in LOCKED or mid-packet: reset wins over release. At the next edge the block is in the full reset state and the in-flight packet ownership is discarded.
- Invariant: grant_o is either 0 or one-hot, and grant_valid_o == |grant_o.

Test Plan:
1. Reset with all inputs valid toward PORT_ID -> the cycle after the reset edge: grant_o=0, grant_valid_o=0, rr_ptr_o=0. First grant appears one cycle after reset deasserts.
2. NUM_IN=4, PORT_ID=0, rr_ptr=0, inputs 1 and 3 valid with addr 0 -> one cycle later grant_o=4'b0010, grant_idx_o=1.
3. Input 1 sends a 3-flit packet, out_ready_i toggling 1,0,1,1 and input 3 requesting throughout -> grant stays 4'b0010 until the tail transfer. Then one bubble cycle with grant_o=0 and rr_ptr_o=2. Then grant_o=4'b1000.
4. LOCK_EN=0, all 4 inputs continuously valid with addr 0, out_ready_i=1 -> grant index sequence 0,1,2,3,0,..., each separated by one bubble, with rr_ptr_o wrapping 3 to 0.
5. Input 2 valid with addr 3'd1 and no other valid input -> grant_valid_o stays 0 indefinitely.
6. Reset asserted while LOCKED on input 3 mid-packet -> next edge: grant_o=0, rr_ptr_o=0, state IDLE. With inputs 0 and 3 requesting after reset, the grant goes to 0.

Source files
------------

// File: rtl/rr_output_arbiter.sv
// Round-robin arbiter for one router output port; grants one input and holds it head-to-tail.
// Latency: request to registered grant is 1 cycle; one idle bubble follows every release.
// Backpressure: out_ready_i gates transfer_o; a stalled or invalid owner keeps the grant.
module rr_output_arbiter #(
  parameter int                NUM_IN  = 4,
  parameter int                ADDR_W  = 3,
  parameter logic [ADDR_W-1:0] PORT_ID = '0,
  parameter bit                LOCK_EN = 1'b1,
  parameter int                IDX_W   = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*ADDR_W-1:0] nexthop_addr_i,
  input  logic [NUM_IN-1:0]        valid_i,
  input  logic [NUM_IN-1:0]        tail_i,
  input  logic                     out_ready_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic [IDX_W-1:0]         grant_idx_o,
  output logic                     grant_valid_o,
  output logic                     transfer_o,
  output logic [IDX_W-1:0]         rr_ptr_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
  localparam logic [IDX_W:0]   NUM_IN_W = (IDX_W + 1)'(NUM_IN);

  state_t              state_q, state_d;
  logic [NUM_IN-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  logic                grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_IN-1:0]   req;
  logic                req_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                transfer;
  logic                release_pkt;
  logic [IDX_W-1:0]    ptr_after_owner;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_req
    assign req[g] = valid_i[g] & (nexthop_addr_i[g*ADDR_W +: ADDR_W] == PORT_ID);
  end

  // Cyclic scan from rr_ptr; the modulo is done by a single conditional subtract
  // so non-power-of-two NUM_IN wraps correctly.
  always_comb begin
    logic [IDX_W:0] cand;
    req_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (cand >= NUM_IN_W) begin
        cand = cand - NUM_IN_W;
      end
      if (!req_found && req[cand[IDX_W-1:0]]) begin
        req_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign transfer        = grant_valid_q & valid_i[grant_idx_q] & out_ready_i;
  assign release_pkt     = transfer & (!LOCK_EN | tail_i[grant_idx_q]);
  assign ptr_after_owner = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    rr_ptr_d      = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          state_d          = LOCKED;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          grant_idx_d      = sel_idx;
          grant_valid_d    = 1'b1;
        end
      end
      LOCKED: begin
        // Body flits carry no address, so only the owner's valid/tail matter here.
        if (release_pkt) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          rr_ptr_d      = ptr_after_owner;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;
  assign transfer_o    = transfer;
  assign rr_ptr_o      = rr_ptr_q;

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter: a packet-mode instance and a single-flit-mode
// instance share the same stimulus; each task checks its own scenario.
module tb_rr_output_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  addr [4];
  logic [11:0] nexthop;
  logic [3:0]  valid;
  logic [3:0]  tail;
  logic        ready;

  logic [3:0]  grant, nl_grant;
  logic [1:0]  gidx, nl_gidx;
  logic        gvld, nl_gvld;
  logic        xfer, nl_xfer;
  logic [1:0]  rr, nl_rr;

  int errors = 0;
  int checks = 0;

  assign nexthop = {addr[3], addr[2], addr[1], addr[0]};

  rr_output_arbiter #(.NUM_IN(4), .ADDR_W(3), .PORT_ID(3'd0), .LOCK_EN(1'b1), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .nexthop_addr_i(nexthop), .valid_i(valid), .tail_i(tail),
    .out_ready_i(ready), .grant_o(grant), .grant_idx_o(gidx), .grant_valid_o(gvld),
    .transfer_o(xfer), .rr_ptr_o(rr)
  );

  rr_output_arbiter #(.NUM_IN(4), .ADDR_W(3), .PORT_ID(3'd0), .LOCK_EN(1'b0), .IDX_W(2)) dut_nl (
    .clk(clk), .reset(reset), .nexthop_addr_i(nexthop), .valid_i(valid), .tail_i(tail),
    .out_ready_i(ready), .grant_o(nl_grant), .grant_idx_o(nl_gidx), .grant_valid_o(nl_gvld),
    .transfer_o(nl_xfer), .rr_ptr_o(nl_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid = 4'b0000;
    tail  = 4'b0000;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) addr[i] = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    valid = 4'b1111;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL reset_gvld: got %b want 0", gvld); end
    checks++; if (rr !== 2'd0) begin errors++; $display("FAIL reset_rr: got %0d want 0", rr); end
    checks++; if (gidx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", gidx); end
    checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL reset_xfer: got %b want 0", xfer); end
    reset = 1'b0;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
  endtask

  task automatic test_grant();
    do_reset();
    valid = 4'b1010;
    ready = 1'b1;
    #1;
    checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL grant_latency: got gvld %b want 0", gvld); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL grant_onehot: got %b want 0010", grant); end
    checks++; if (gidx !== 2'd1) begin errors++; $display("FAIL grant_idx: got %0d want 1", gidx); end
    checks++; if (rr !== 2'd0) begin errors++; $display("FAIL grant_rr_unchanged: got %0d want 0", rr); end
  endtask

  // Continues from test_grant: input 1 owns the port, input 3 keeps requesting.
  task automatic test_packet();
    ready = 1'b1; valid = 4'b1010; tail = 4'b0000;
    #1;
    checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL pkt_head_xfer: got %b want 1", xfer); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pkt_hold_a: got %b want 0010", grant); end
    ready = 1'b0;
    #1;
    checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL pkt_stall_xfer: got %b want 0", xfer); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pkt_hold_b: got %b want 0010", grant); end
    ready = 1'b1; valid = 4'b1000; tail = 4'b0010;
    #1;
    checks++; if (xfer !== 1'b0) begin errors++; $display("FAIL pkt_owner_idle_xfer: got %b want 0", xfer); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pkt_owner_idle_hold: got %b want 0010", grant); end
    valid = 4'b1010; tail = 4'b0000; addr[1] = 3'd5;
    #1;
    checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL pkt_body_xfer: got %b want 1", xfer); end
    step();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL pkt_body_hold: got %b want 0010", grant); end
    tail = 4'b0010;
    #1;
    checks++; if (xfer !== 1'b1) begin errors++; $display("FAIL pkt_tail_xfer: got %b want 1", xfer); end
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL pkt_bubble_grant: got %b want 0000", grant); end
    checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL pkt_bubble_gvld: got %b want 0", gvld); end
    checks++; if (rr !== 2'd2) begin errors++; $display("FAIL pkt_bubble_rr: got %0d want 2", rr); end
    checks++; if (gidx !== 2'd1) begin errors++; $display("FAIL pkt_bubble_idx_hold: got %0d want 1", gidx); end
    valid = 4'b1000; tail = 4'b0000; addr[1] = 3'd0;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL pkt_next_grant: got %b want 1000", grant); end
    checks++; if (gidx !== 2'd3) begin errors++; $display("FAIL pkt_next_idx: got %0d want 3", gidx); end
    checks++; if (rr !== 2'd2) begin errors++; $display("FAIL pkt_next_rr: got %0d want 2", rr); end
  endtask

  task automatic test_single_flit();
    logic [3:0] exp_oh;
    do_reset();
    valid = 4'b1111; ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_oh = 4'b0001 << (n % 4);
      step();
      checks++; if (nl_gvld !== 1'b1 || nl_grant !== exp_oh || nl_gidx !== 2'(n % 4)) begin
        errors++; $display("FAIL sf_grant_%0d: got %b idx %0d want %b idx %0d", n, nl_grant, nl_gidx, exp_oh, n % 4);
      end
      step();
      checks++; if (nl_gvld !== 1'b0 || nl_rr !== 2'((n + 1) % 4)) begin
        errors++; $display("FAIL sf_bubble_%0d: got gvld %b rr %0d want 0 rr %0d", n, nl_gvld, nl_rr, (n + 1) % 4);
      end
    end
  endtask

  task automatic test_wrong_port();
    do_reset();
    valid = 4'b0100; addr[2] = 3'd1; ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      checks++; if (gvld !== 1'b0) begin errors++; $display("FAIL wrong_port_%0d: got gvld %b want 0", n, gvld); end
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    valid = 4'b1000; ready = 1'b1;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL rl_lock: got %b want 1000", grant); end
    step();
    valid = 4'b1001; tail = 4'b1000; reset = 1'b1;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rl_grant: got %b want 0000", grant); end
    checks++; if (rr !== 2'd0) begin errors++; $display("FAIL rl_rr: got %0d want 0", rr); end
    checks++; if (gidx !== 2'd0) begin errors++; $display("FAIL rl_idx: got %0d want 0", gidx); end
    reset = 1'b0; tail = 4'b0000;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rl_after: got %b want 0001", grant); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_grant();
    test_packet();
    test_single_flit();
    test_wrong_port();
    test_reset_locked();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
